block_memory: RTL and testbench

Parametrised, handshaked main-memory model serving the cache's line fills and write-throughs. A read request returns one aligned block of BLOCKSIZE words as a burst of one word per cycle after a programmable access latency. A write request stores one word in the accept cycle. The block sits between the cache controller and backing storage and supersedes the flat, combinational four-port block read.

---
 rtl/block_memory_if.sv | 32 +++
 rtl/block_memory.sv | 122 ++++++++++++
 tb/tb_block_memory.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_memory_if.sv
// block_memory_if
//   Request/response bundle between the cache controller (master) and the
//   block_memory model (slave).
//   Request : reqValid, reqReady, reqWrite, reqAddr, reqWData
//   Response: rspValid, rspData, rspIdx, rspLast
interface block_memory_if #(
  parameter int WORD      = 32,
  parameter int ADDRESSL  = 15,
  parameter int BLOCKSIZE = 4
);
  localparam int IDXW = $clog2(BLOCKSIZE);

  logic                reqValid;
  logic                reqReady;
  logic                reqWrite;
  logic [ADDRESSL-1:0] reqAddr;
  logic [WORD-1:0]     reqWData;
  logic                rspValid;
  logic [WORD-1:0]     rspData;
  logic [IDXW-1:0]     rspIdx;
  logic                rspLast;

  modport master (
    output reqValid, reqWrite, reqAddr, reqWData,
    input  reqReady, rspValid, rspData, rspIdx, rspLast
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWData,
    output reqReady, rspValid, rspData, rspIdx, rspLast
  );
endinterface

// File: rtl/block_memory.sv
// block_memory
//   Handshaked main-memory model. A read returns one aligned block of
//   BLOCKSIZE words, one word per cycle, after LATENCY wait cycles. A write
//   stores a single word in the accept cycle and produces no response.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset (memory contents are kept)
//   bus    : block_memory_if slave modport (request and response channels)
//
// Optional feature
//   BLOCK_MEM_CWF_EN : critical word first; the burst starts at the requested
//                      word and wraps within the block. Without it every
//                      burst starts at offset 0.
//
// The storage array has no reset and relies on zero power-up contents.
module block_memory #(
  parameter int WORD      = 32,
  parameter int LENGTH    = 32768,
  parameter int ADDRESSL  = 15,
  parameter int BLOCKSIZE = 4,
  parameter int LATENCY   = 2
) (
  input logic          clk,
  input logic          rst_n,
  block_memory_if.slave bus
);

  localparam int IDXW = $clog2(BLOCKSIZE);
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNTW-1:0]   LAT_LOAD  = CNTW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDRESSL:0] LIMIT     = (ADDRESSL + 1)'(LENGTH);
  localparam logic [IDXW-1:0]   LAST_BEAT = IDXW'(BLOCKSIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                     state;
  logic [WORD-1:0]            mem [0:LENGTH-1];
  logic [CNTW-1:0]            wait_cnt;
  logic [ADDRESSL-IDXW-1:0]   block_tag;
  logic [IDXW-1:0]            idx;
  logic [IDXW-1:0]            beat_cnt;
  logic [IDXW-1:0]            start_idx;
  logic                       accept;
  logic                       write_ok;
  logic [ADDRESSL-1:0]        beat_addr;
  logic [WORD-1:0]            beat_data;

  assign bus.reqReady = (state == IDLE);
  assign accept       = rst_n && bus.reqValid && (state == IDLE);
  // Out-of-range writes are dropped silently.
  assign write_ok     = accept && bus.reqWrite && ({1'b0, bus.reqAddr} < LIMIT);
  // Block base is aligned, so the beat address is a concatenation, never a carry.
  assign beat_addr    = {block_tag, idx};

`ifdef BLOCK_MEM_CWF_EN
  assign start_idx = bus.reqAddr[IDXW-1:0];
`else
  assign start_idx = '0;
`endif

  // Out-of-range reads return zero instead of touching the array.
  always_comb begin
    beat_data = '0;
    if ({1'b0, beat_addr} < LIMIT) beat_data = mem[beat_addr];
  end

  always_ff @(posedge clk) begin
    if (write_ok) mem[bus.reqAddr] <= bus.reqWData;
  end

  // Response registers default to zero every cycle; only BURST drives a beat,
  // which keeps the idle response at zero without extra decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      block_tag    <= '0;
      idx          <= '0;
      beat_cnt     <= '0;
      bus.rspValid <= 1'b0;
      bus.rspData  <= '0;
      bus.rspIdx   <= '0;
      bus.rspLast  <= 1'b0;
    end else begin
      bus.rspValid <= 1'b0;
      bus.rspData  <= '0;
      bus.rspIdx   <= '0;
      bus.rspLast  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !bus.reqWrite) begin
            block_tag <= bus.reqAddr[ADDRESSL-1:IDXW];
            idx       <= start_idx;
            beat_cnt  <= '0;
            if (LATENCY > 0) begin
              state    <= WAIT;
              wait_cnt <= LAT_LOAD;
            end else begin
              state <= BURST;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= BURST;
          else                wait_cnt <= wait_cnt - CNTW'(1);
        end
        BURST: begin
          bus.rspValid <= 1'b1;
          bus.rspData  <= beat_data;
          bus.rspIdx   <= idx;
          bus.rspLast  <= (beat_cnt == LAST_BEAT);
          idx          <= idx + IDXW'(1);
          beat_cnt     <= beat_cnt + IDXW'(1);
          if (beat_cnt == LAST_BEAT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_memory.sv
// tb_block_memory
//   Drives two block_memory instances (LATENCY=0 and LATENCY=2) and checks
//   them against a transaction-level model: every accepted read schedules its
//   BLOCKSIZE beats at absolute edge numbers, and each falling edge compares
//   the DUT response and reqReady with what the schedule says.
//   Hand-computed literal checks pin the model on the directed scenarios.
module tb_block_memory;

  localparam int WORD      = 32;
  localparam int LENGTH    = 32768;
  localparam int ADDRESSL  = 15;
  localparam int BLOCKSIZE = 4;

`ifdef BLOCK_MEM_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_memory_if #(.WORD(WORD), .ADDRESSL(ADDRESSL), .BLOCKSIZE(BLOCKSIZE)) bus0 ();
  block_memory_if #(.WORD(WORD), .ADDRESSL(ADDRESSL), .BLOCKSIZE(BLOCKSIZE)) bus2 ();

  block_memory #(.WORD(WORD), .LENGTH(LENGTH), .ADDRESSL(ADDRESSL),
                 .BLOCKSIZE(BLOCKSIZE), .LATENCY(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  block_memory #(.WORD(WORD), .LENGTH(LENGTH), .ADDRESSL(ADDRESSL),
                 .BLOCKSIZE(BLOCKSIZE), .LATENCY(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  int nChecks = 0;
  int nPass   = 0;
  int edge_cnt = 0;

  typedef struct {
    int         dev;
    int         edge_no;
    logic [31:0] data;
    int         idx;
    bit         last;
  } beat_t;

  beat_t       sched[$];
  logic [31:0] mem_m [int];

  function automatic int latOf(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] memRead(int d, int a);
    if (a >= LENGTH) return 32'h0;
    if (mem_m.exists(d * 65536 + a)) return mem_m[d * 65536 + a];
    return 32'h0;
  endfunction

  function automatic bit busy(int d);
    foreach (sched[j]) if (sched[j].dev == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic dutReady(int d);
    return (d == 0) ? bus0.reqReady : bus2.reqReady;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: accepts requests exactly when no burst is outstanding and turns
  // each read into a list of beats at absolute edge numbers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched.delete();
    end else begin
      edge_cnt++;
      for (int d = 0; d < 2; d++) begin
        logic v, w;
        int a;
        logic [31:0] wd;
        v  = (d == 0) ? bus0.reqValid : bus2.reqValid;
        w  = (d == 0) ? bus0.reqWrite : bus2.reqWrite;
        a  = int'((d == 0) ? bus0.reqAddr : bus2.reqAddr);
        wd = (d == 0) ? bus0.reqWData : bus2.reqWData;
        if (v && !busy(d)) begin
          if (w) begin
            if (a < LENGTH) mem_m[d * 65536 + a] = wd;
          end else begin
            int base, start;
            base  = a - (a % BLOCKSIZE);
            start = CWF ? (a % BLOCKSIZE) : 0;
            for (int k = 0; k < BLOCKSIZE; k++) begin
              beat_t b;
              b.dev     = d;
              b.edge_no = edge_cnt + latOf(d) + 1 + k;
              b.idx     = (start + k) % BLOCKSIZE;
              b.data    = memRead(d, base + b.idx);
              b.last    = (k == BLOCKSIZE - 1);
              sched.push_back(b);
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, both DUTs.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        v, l, r;
      logic [31:0] dat;
      int          ix, found;
      string       tag;
      v   = (d == 0) ? bus0.rspValid : bus2.rspValid;
      l   = (d == 0) ? bus0.rspLast  : bus2.rspLast;
      r   = (d == 0) ? bus0.reqReady : bus2.reqReady;
      dat = (d == 0) ? bus0.rspData  : bus2.rspData;
      ix  = int'((d == 0) ? bus0.rspIdx : bus2.rspIdx);
      tag = $sformatf("dut%0d edge %0d", (d == 0) ? 0 : 2, edge_cnt);
      found = -1;
      if (rst_n) begin
        foreach (sched[j])
          if (found < 0 && sched[j].dev == d && sched[j].edge_no == edge_cnt) found = j;
      end
      if (found >= 0) begin
        checkOutput({tag, " rspValid"}, 32'(v), 32'd1);
        checkOutput({tag, " rspData"}, dat, sched[found].data);
        checkOutput({tag, " rspIdx"}, 32'(ix), 32'(sched[found].idx));
        checkOutput({tag, " rspLast"}, 32'(l), 32'(sched[found].last));
        sched.delete(found);
      end else begin
        checkOutput({tag, " rspValid"}, 32'(v), 32'd0);
        checkOutput({tag, " rspData"}, dat, 32'd0);
        checkOutput({tag, " rspIdx"}, 32'(ix), 32'd0);
        checkOutput({tag, " rspLast"}, 32'(l), 32'd0);
      end
      checkOutput({tag, " reqReady"}, 32'(r), rst_n ? 32'(!busy(d)) : 32'd1);
    end
  end

  task automatic applyStimulus(input int d, input logic v, input logic w,
                               input int a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.reqValid = v; bus0.reqWrite = w;
      bus0.reqAddr = a[ADDRESSL-1:0]; bus0.reqWData = wd;
    end else begin
      bus2.reqValid = v; bus2.reqWrite = w;
      bus2.reqAddr = a[ADDRESSL-1:0]; bus2.reqWData = wd;
    end
  endtask

  // Presents a request (called 2 time units after a rising edge) and waits
  // for it to be taken; returns the accept edge number. Valid stays high.
  task automatic doReq(input int d, input logic w, input int a,
                       input logic [31:0] wd, output int acc);
    applyStimulus(d, 1'b1, w, a, wd);
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      if (dutReady(d)) begin
        @(posedge clk); #2;
        acc = edge_cnt;
        return;
      end
      @(posedge clk); #2;
    end
    nChecks++;
    $display("[TB] FAIL accept timeout dut%0d addr 0x%0h: not accepted, required within 40 cycles", d, a);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e, e1, e2, k, ix;
    applyStimulus(0, 1'b0, 1'b0, 0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);

    // Reset state
    @(negedge clk);
    checkOutput("reset reqReady", 32'(bus2.reqReady), 32'd1);
    checkOutput("reset rspValid", 32'(bus2.rspValid), 32'd0);
    checkOutput("reset rspData", bus2.rspData, 32'd0);
    checkOutput("reset rspLast", 32'(bus2.rspLast), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;

    // Back-to-back writes 0xA0..0xA3 then read of 0x10 on the next edge
    for (int i = 0; i < 4; i++) doReq(1, 1'b1, 'h10 + i, 32'hA0 + i, e);
    doReq(1, 1'b0, 'h10, 32'h0, e);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("read10 +%0d reqReady", i), 32'(bus2.reqReady), (i >= 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("read10 +%0d rspValid", i), 32'(bus2.rspValid), (i >= 3 && i <= 6) ? 32'd1 : 32'd0);
      if (i >= 3 && i <= 6) begin
        checkOutput($sformatf("read10 beat%0d data", i - 3), bus2.rspData, 32'hA0 + 32'(i - 3));
        checkOutput($sformatf("read10 beat%0d idx", i - 3), 32'(bus2.rspIdx), 32'(i - 3));
        checkOutput($sformatf("read10 beat%0d last", i - 3), 32'(bus2.rspLast), (i == 6) ? 32'd1 : 32'd0);
      end
    end
    @(posedge clk); #2;

    // Read of 0x12: beat order depends on critical-word-first
    doReq(1, 1'b0, 'h12, 32'h0, e);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        k  = i - 3;
        ix = CWF ? (2 + k) % 4 : k;
        checkOutput($sformatf("read12 beat%0d idx", k), 32'(bus2.rspIdx), 32'(ix));
        checkOutput($sformatf("read12 beat%0d data", k), bus2.rspData, 32'hA0 + 32'(ix));
      end
    end
    @(posedge clk); #2;

    // Write presented while a burst is in flight must be ignored
    doReq(1, 1'b0, 'h10, 32'h0, e);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 1'b1, 'h11, 32'hDEAD);
      @(posedge clk); #2;
    end
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    idleCycles(3);
    doReq(1, 1'b0, 'h11, 32'h0, e);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        k  = i - 3;
        ix = CWF ? (1 + k) % 4 : k;
        checkOutput($sformatf("readback11 beat%0d data", k), bus2.rspData, 32'hA0 + 32'(ix));
      end
    end
    @(posedge clk); #2;

    // Top-of-memory block: no wrap into address 0
    doReq(1, 1'b1, 'h0, 32'h12345678, e);
    doReq(1, 1'b1, 'h7FFF, 32'hCAFEF00D, e);
    doReq(1, 1'b0, 'h7FFC, 32'h0, e);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        k = i - 3;
        checkOutput($sformatf("top beat%0d data", k), bus2.rspData, (k == 3) ? 32'hCAFEF00D : 32'h0);
        checkOutput($sformatf("top beat%0d idx", k), 32'(bus2.rspIdx), 32'(k));
      end
    end
    @(posedge clk); #2;

    // Reset in the third beat of a burst
    doReq(1, 1'b0, 'h10, 32'h0, e);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset rspValid", 32'(bus2.rspValid), 32'd0);
    checkOutput("midreset rspLast", 32'(bus2.rspLast), 32'd0);
    checkOutput("midreset rspData", bus2.rspData, 32'd0);
    checkOutput("midreset reqReady", 32'(bus2.reqReady), 32'd1);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;
    checkOutput("after reset reqReady", 32'(bus2.reqReady), 32'd1);
    doReq(1, 1'b0, 'h10, 32'h0, e);
    applyStimulus(1, 1'b0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        k = i - 3;
        checkOutput($sformatf("postreset beat%0d data", k), bus2.rspData, 32'hA0 + 32'(k));
        checkOutput($sformatf("postreset beat%0d last", k), 32'(bus2.rspLast), (k == 3) ? 32'd1 : 32'd0);
      end
    end
    @(posedge clk); #2;

    // LATENCY=0: two reads with reqValid held high
    for (int i = 0; i < 4; i++) doReq(0, 1'b1, 'h10 + i, 32'hB0 + i, e);
    doReq(0, 1'b1, 'h22, 32'hC2, e);
    doReq(0, 1'b0, 'h10, 32'h0, e1);
    doReq(0, 1'b0, 'h20, 32'h0, e2);
    applyStimulus(0, 1'b0, 1'b0, 0, 32'h0);
    checkOutput("lat0 second accept offset", 32'(e2 - e1), 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        k  = i - 1;
        ix = CWF ? k : k;
        checkOutput($sformatf("lat0 read20 beat%0d data", k), bus0.rspData, (ix == 2) ? 32'hC2 : 32'h0);
        checkOutput($sformatf("lat0 read20 beat%0d idx", k), 32'(bus0.rspIdx), 32'(ix));
      end
    end
    @(posedge clk); #2;
    idleCycles(4);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
